// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the pingpong button conditioner.
// The optional toggle-hold mode is selected with PINGPONG_HOLD_TOGGLE_EN.
package pingpong_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'b00,
        CHK_HI = 2'b01,
        S_HI   = 2'b10,
        CHK_LO = 2'b11
    } db_state_e;

    localparam int DB_CYCLES_DEF = 16;
    localparam int NUM_CH        = 2;
    localparam int CH_HOLD       = 0;
    localparam int CH_FLIP       = 1;

    function automatic logic db_level(input db_state_e st);
        return (st == S_HI) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM with a qualification
// counter, registered level plus single-cycle rise/fall pulses.
module btn_debounce
    import pingpong_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = $clog2(DB_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             level_q, level_d;
    logic             s2;

    assign s2 = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LO: begin
                if (s2) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_d = S_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HI: begin
                if (!s2) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s2) begin
                    state_d = S_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_LO;
        endcase
        // Level is taken from the next state so it is a plain flop output.
        level_d = db_level(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= S_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pingpong_btn_cond.sv
// Conditions the hold/flip push-buttons for the pingpong counter.
// PINGPONG_HOLD_TOGGLE_EN turns hold into a press-to-toggle register.
module pingpong_btn_cond
    import pingpong_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = $clog2(DB_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_hold_raw,
    input  logic btn_flip_raw,
    output logic hold,
    output logic flip
);

    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] db_level;
    logic [NUM_CH-1:0] db_rise;
    logic [NUM_CH-1:0] db_fall;

    assign btn_raw[CH_HOLD] = btn_hold_raw;
    assign btn_raw[CH_FLIP] = btn_flip_raw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[g]),
            .level   (db_level[g]),
            .rise    (db_rise[g]),
            .fall    (db_fall[g])
        );
    end

    assign flip = db_rise[CH_FLIP];

`ifdef PINGPONG_HOLD_TOGGLE_EN
    logic hold_q, hold_d;

    always_comb begin
        hold_d = hold_q ^ db_rise[CH_HOLD];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= 1'b0;
        else        hold_q <= hold_d;
    end

    assign hold = hold_q;
`else
    assign hold = db_level[CH_HOLD];
`endif

endmodule

// File: tb/tb_pingpong_btn_cond.sv
// Scoreboard bench: a run-length debounce model predicts hold/flip each
// cycle; a negedge monitor pops predictions and compares against the DUT.
module tb_pingpong_btn_cond;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_hold_raw = 1'b0;
    logic btn_flip_raw = 1'b0;
    wire  hold;
    wire  flip;

    always #10 clk = ~clk;

    pingpong_btn_cond #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_hold_raw (btn_hold_raw),
        .btn_flip_raw (btn_flip_raw),
        .hold         (hold),
        .flip         (flip)
    );

    typedef struct {
        logic hold;
        logic flip;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the synchronized sample is the raw value two edges old; the
    // accepted level flips once DB consecutive samples disagree with it.
    int m_h1[2], m_h2[2], m_lvl[2], m_run[2], m_rise[2], m_raw[2];
    int m_tog, m_prev_rise_hold, m_s2;
    exp_t m_e;

    always @(posedge clk) begin
        m_raw[0] = int'(btn_hold_raw);
        m_raw[1] = int'(btn_flip_raw);
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_h1[c] = 0; m_h2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_rise[c] = 0;
            end
            m_tog = 0;
            m_prev_rise_hold = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_s2    = m_h2[c];
                m_h2[c] = m_h1[c];
                m_h1[c] = m_raw[c];
                m_rise[c] = 0;
                if (m_s2 != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_lvl[c]  = m_s2;
                        m_run[c]  = 0;
                        m_rise[c] = m_s2;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_tog = m_tog ^ m_prev_rise_hold;
            m_prev_rise_hold = m_rise[0];
        end
`ifdef PINGPONG_HOLD_TOGGLE_EN
        m_e.hold = (m_tog != 0);
`else
        m_e.hold = (m_lvl[0] != 0);
`endif
        m_e.flip = (m_rise[1] != 0);
        exp_q.push_back(m_e);
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (hold !== mon_e.hold) begin
                errors++;
                $display("FAIL hold @%0t: got %b expected %b", $time, hold, mon_e.hold);
            end
            checks++;
            if (flip !== mon_e.flip) begin
                errors++;
                $display("FAIL flip @%0t: got %b expected %b", $time, flip, mon_e.flip);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held with idle buttons, then released idle.
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        // Clean flip press.
        btn_flip_raw = 1'b1; cycles(10);
        btn_flip_raw = 1'b0; cycles(10);

        // Bouncy flip press that never qualifies.
        repeat (4) begin
            btn_flip_raw = 1'b1; cycles(3);
            btn_flip_raw = 1'b0; cycles(1);
        end
        cycles(10);

        // Two separate hold presses.
        repeat (2) begin
            btn_hold_raw = 1'b1; cycles(8);
            btn_hold_raw = 1'b0; cycles(12);
        end

        // Both buttons on the same edge.
        btn_hold_raw = 1'b1; btn_flip_raw = 1'b1; cycles(10);
        btn_hold_raw = 1'b0; btn_flip_raw = 1'b0; cycles(12);

        // Reset in the middle of qualification, button still pressed after.
        btn_flip_raw = 1'b1; cycles(4);
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; cycles(12);
        btn_flip_raw = 1'b0; cycles(12);

        // Random segments: mix of short glitches and long holds, rare resets.
        repeat (300) begin
            btn_hold_raw = 1'($urandom_range(0, 1));
            btn_flip_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
            cycles(1);
            rst_n = 1'b1;
            cycles(($urandom_range(0, 2) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3));
        end

        btn_hold_raw = 1'b0; btn_flip_raw = 1'b0;
        cycles(15);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
